activ_tile: RTL and testbench

// - Activation stage of the TPU datapath: applies ReLU to four 8-bit lanes arriving from the array.
// - Collects four valid beats per lane into a 4x4-byte (128-bit) output tile.
// - Emits the tile with a one-cycle valid pulse.
// - Sits between the systolic-array accumulators and the unified output buffer.

---
 rtl/tpu_pkg.sv | 18 +
 rtl/activ_lane.sv | 47 ++++
 rtl/activ_tile.sv | 43 ++++
 tb/tb_activ_tile.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// TPU shared definitions.
// Lane geometry, element type and ReLU helper.
package tpu_pkg;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int BEATS = 4;
  localparam int WW    = DW * BEATS;
  localparam int TW    = WW * LANES;

  typedef logic [DW-1:0] byte_t;

  // Signed ReLU on one element: negatives clamp to zero.
  function automatic byte_t relu(byte_t x);
    return x[DW-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/activ_lane.sv
// One activation lane: ReLU, byte shift buffer,
// saturating beat counter and full flag.
module activ_lane
  import tpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          dv,
  input  byte_t         din,
  output logic [WW-1:0] word_nxt,
  output logic          full_nxt
);

  logic [WW-1:0] fill;
  logic [2:0]    cnt;
  logic [2:0]    cnt_nxt;
  logic          full;
  logic          acc;

  assign full = (cnt == 3'(BEATS));
  assign acc  = dv && !full;

  // Next fill/count including a beat accepted this edge.
  always_comb begin
    word_nxt = fill;
    cnt_nxt  = cnt;
    if (acc) begin
      word_nxt = {fill[WW-DW-1:0], relu(din)};
      cnt_nxt  = cnt + 3'd1;
    end
  end

  assign full_nxt = (cnt_nxt == 3'(BEATS));

  // Buffer and counter; clr restarts counting for the next tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill <= '0;
      cnt  <= '0;
    end else begin
      fill <= word_nxt;
      cnt  <= clr ? 3'd0 : cnt_nxt;
    end
  end

endmodule

// File: rtl/activ_tile.sv
// Activation tile: four ReLU lanes gathered into
// a 128-bit tile with a one-cycle valid pulse.
module activ_tile
  import tpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES-1:0]    dv_acin,
  input  logic [LANES*DW-1:0] acin,
  output logic                dv_acout,
  output logic [TW-1:0]       acout
);

  logic [TW-1:0]    words;
  logic [LANES-1:0] full_nxt;
  logic             done;

  assign done = &full_nxt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    activ_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (done),
      .dv       (dv_acin[i]),
      .din      (acin[DW*i +: DW]),
      .word_nxt (words[WW*i +: WW]),
      .full_nxt (full_nxt[i])
    );
  end

  // Capture the tile and pulse valid when every lane fills.
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_acout <= 1'b0;
      acout    <= '0;
    end else begin
      dv_acout <= done;
      if (done) acout <= words;
    end
  end

endmodule

// File: tb/tb_activ_tile.sv
// Directed vector bench for activ_tile.
// Rows give one edge of stimulus and the outputs after it.
module tb_activ_tile;

  typedef struct {
    logic          rst;
    logic [3:0]    dv;
    logic [31:0]   acin;
    logic          exp_dv;
    logic [127:0]  exp_acout;
  } vec_t;

  localparam logic [127:0] T_ALIGN =
    128'h0B0B0964_00090B01_00090B64_000B0901;
  localparam logic [127:0] T_RELU =
    {4{32'h00007F6E}};
  localparam logic [127:0] T_SKEW =
    128'h40414243_30313233_20212223_10111213;
  localparam logic [127:0] T_OVF =
    128'h41424344_31323334_21222324_01020304;
  localparam logic [127:0] T_A =
    128'h04080C10_03070B0F_02060A0E_0105090D;
  localparam logic [127:0] T_B =
    128'h14181C20_13171B1F_12161A1E_1115191D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   dv_acin = '0;
  logic [31:0]  acin = '0;
  logic         dv_acout;
  logic [127:0] acout;

  vec_t         vq[$];
  logic [127:0] hold = '0;
  int           n_run = 0;
  int           n_fail = 0;

  activ_tile dut (
    .clk      (clk),
    .rst      (rst),
    .dv_acin  (dv_acin),
    .acin     (acin),
    .dv_acout (dv_acout),
    .acout    (acout)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] d,
                     input logic [31:0] a, input logic p,
                     input logic [127:0] t);
    vec_t v;
    if (r) hold = '0;
    else if (p) hold = t;
    v.rst = r;
    v.dv = d;
    v.acin = a;
    v.exp_dv = p;
    v.exp_acout = hold;
    vq.push_back(v);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  d;

    // reset with valid beats pending
    add(1, 4'hF, 32'h11111111, 0, '0);
    add(1, 4'hF, 32'h22222222, 0, '0);
    // aligned fill
    add(0, 4'hF, 32'h0B000000, 0, '0);
    add(0, 4'hF, 32'h0B09090B, 0, '0);
    add(0, 4'hF, 32'h090B0B09, 0, '0);
    add(0, 4'hF, 32'h64016401, 1, T_ALIGN);
    add(0, 4'h0, 32'h12345678, 0, '0);
    // relu
    add(0, 4'hF, 32'h80808080, 0, '0);
    add(0, 4'hF, 32'hFFFFFFFF, 0, '0);
    add(0, 4'hF, 32'h7F7F7F7F, 0, '0);
    add(0, 4'hF, 32'h6E6E6E6E, 1, T_RELU);
    add(0, 4'h0, 32'h0, 0, '0);
    // skew: lane i valid on cycles i..i+3
    for (int c = 0; c < 7; c++) begin
      a = 32'h55555555;
      d = '0;
      for (int i = 0; i < 4; i++)
        if (c >= i && c <= i + 3) begin
          d[i] = 1'b1;
          a[8*i +: 8] = 8'(16 * (i + 1) + (c - i));
        end
      add(0, d, a, c == 6, T_SKEW);
    end
    add(0, 4'h0, 32'h0, 0, '0);
    // overflow: lane 0 keeps sending while others lag
    for (int c = 0; c < 7; c++) begin
      a = 32'h55555555;
      d = 4'b0001;
      a[7:0] = 8'(c + 1);
      for (int i = 1; i < 4; i++)
        if (c >= 3) begin
          d[i] = 1'b1;
          a[8*i +: 8] = 8'(16 * (i + 1) + 1 + (c - 3));
        end
      add(0, d, a, c == 6, T_OVF);
    end
    // back-to-back tiles
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++)
        a[8*i +: 8] = 8'(4 * c + i + 1);
      add(0, 4'hF, a, c == 3 || c == 7, c < 4 ? T_A : T_B);
    end
    add(0, 4'h0, 32'h0, 0, '0);
    // mid-tile reset
    add(0, 4'hF, 32'h77777777, 0, '0);
    add(0, 4'hF, 32'h77777777, 0, '0);
    add(1, 4'hF, 32'h7F7F7F7F, 0, '0);
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++)
        a[8*i +: 8] = 8'(4 * c + i + 1);
      add(0, 4'hF, a, c == 3, T_A);
    end
    add(0, 4'h0, 32'h0, 0, '0);

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      rst = vq[k].rst;
      dv_acin = vq[k].dv;
      acin = vq[k].acin;
      @(posedge clk);
      #1;
      n_run++;
      if (dv_acout !== vq[k].exp_dv) begin
        n_fail++;
        $display("FAIL dv_acout row %0d: got %b want %b",
                 k, dv_acout, vq[k].exp_dv);
      end
      n_run++;
      if (acout !== vq[k].exp_acout) begin
        n_fail++;
        $display("FAIL acout row %0d: got %h want %h",
                 k, acout, vq[k].exp_acout);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
